// File: rtl/h264_bitstream_packer_if.sv
// Handshake bundle between the CAVLC encoder, the bitstream packer and the NAL word writer.
// The packer takes the slave side; the encoder/writer pair (or a bench) takes the master side.
interface h264_bitstream_packer_if #(
    parameter int CNT_W = 24
);
    logic             cavlc_enc_valid;
    logic [127:0]     cavlc_bitstream_code;
    logic [6:0]       cavlc_bitstream_bit;
    logic             packer_ready;
    logic             flush_req;
    logic             word_valid;
    logic             word_ready;
    logic [31:0]      word_data;
    logic             word_last;
    logic [2:0]       word_bytes;
    logic             flush_done;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output cavlc_enc_valid, cavlc_bitstream_code, cavlc_bitstream_bit, flush_req, word_ready,
        input  packer_ready, word_valid, word_data, word_last, word_bytes, flush_done, word_cnt
    );

    modport slave (
        input  cavlc_enc_valid, cavlc_bitstream_code, cavlc_bitstream_bit, flush_req, word_ready,
        output packer_ready, word_valid, word_data, word_last, word_bytes, flush_done, word_cnt
    );
endinterface

// File: rtl/h264_bitstream_packer.sv
// Packs right-aligned CAVLC codewords MSB-first into 32-bit words and closes a slice
// with rbsp trailing bits (stop '1' plus zero pad to a byte boundary) on flush.
module h264_bitstream_packer #(
    parameter int BUF_W     = 192,
    parameter int ACCEPT_TH = 64,
    parameter int CNT_W     = 24
) (
    input logic                   clk,
    input logic                   rst,
    h264_bitstream_packer_if.slave bus
);
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam logic [FILL_W-1:0] WORD_BITS = FILL_W'(32);

    typedef enum logic [2:0] {RUN, DRAIN, PAD, LAST, DONE} state_t;

    state_t            state;
    logic [BUF_W-1:0]  bit_buf;
    logic [FILL_W-1:0] fill;
    logic              live;
    logic [CNT_W-1:0]  cnt;

    logic              acc;
    logic              emit;
    logic [BUF_W-1:0]  shifted;
    logic [FILL_W-1:0] base_fill;
    logic [FILL_W-1:0] len_ext;
    logic [FILL_W:0]   app_sh;
    logic [FILL_W:0]   pad_sh;
    logic [BUF_W-1:0]  code_ext;
    logic [BUF_W-1:0]  buf_acc;
    logic [FILL_W-1:0] fill_acc;
    logic [BUF_W-1:0]  pad_buf;
    logic [FILL_W-1:0] fill_p8;
    logic [FILL_W-1:0] pad_fill;

    // live keeps packer_ready low while in reset and for the edge that releases it
    assign bus.packer_ready = live && (state == RUN) && (fill <= FILL_W'(ACCEPT_TH));
    assign bus.word_valid   = (((state == RUN) || (state == DRAIN)) && (fill >= WORD_BITS))
                              || (state == LAST);
    assign bus.word_data    = bit_buf[BUF_W-1 -: 32];
    assign bus.word_last    = (state == LAST);
    assign bus.word_bytes   = (state == LAST) ? fill[5:3] : 3'd4;
    assign bus.flush_done   = (state == DONE);
    assign bus.word_cnt     = cnt;

    always_comb begin
        acc       = bus.cavlc_enc_valid && bus.packer_ready;
        emit      = bus.word_valid && bus.word_ready && (state != LAST);
        shifted   = emit ? (bit_buf << 32) : bit_buf;
        base_fill = emit ? (fill - WORD_BITS) : fill;
        len_ext   = FILL_W'(bus.cavlc_bitstream_bit);
        // New bits land directly after the (possibly already shifted) fill point
        code_ext  = BUF_W'(bus.cavlc_bitstream_code) & ((BUF_W'(1) << len_ext) - BUF_W'(1));
        app_sh    = (FILL_W+1)'(BUF_W) - {1'b0, base_fill} - {1'b0, len_ext};
        buf_acc   = acc ? (shifted | (code_ext << app_sh)) : shifted;
        fill_acc  = acc ? (base_fill + len_ext) : base_fill;
        // Stop bit at the fill point; the bits behind it are already zero
        pad_sh    = (FILL_W+1)'(BUF_W - 1) - {1'b0, fill};
        pad_buf   = bit_buf | (BUF_W'(1) << pad_sh);
        fill_p8   = fill + FILL_W'(8);
        pad_fill  = {fill_p8[FILL_W-1:3], 3'b000};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            bit_buf <= '0;
            fill    <= '0;
            live    <= 1'b0;
            cnt     <= '0;
        end else begin
            live <= 1'b1;
            if (bus.word_valid && bus.word_ready)
                cnt <= cnt + CNT_W'(1);
            case (state)
                RUN: begin
                    bit_buf <= buf_acc;
                    fill    <= fill_acc;
                    if (bus.flush_req && bus.packer_ready)
                        state <= DRAIN;
                end
                DRAIN: begin
                    bit_buf <= buf_acc;
                    fill    <= fill_acc;
                    if (fill < WORD_BITS)
                        state <= PAD;
                end
                PAD: begin
                    bit_buf <= pad_buf;
                    fill    <= pad_fill;
                    state   <= LAST;
                end
                LAST: begin
                    if (bus.word_ready) begin
                        bit_buf <= '0;
                        fill    <= '0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_h264_bitstream_packer.sv
// Bench for h264_bitstream_packer: directed slice scenarios plus random traffic, checked
// against a bit-queue model of the emitted stream.
module tb_h264_bitstream_packer;
    logic clk = 1'b0;
    logic rst;

    h264_bitstream_packer_if #(.CNT_W(24)) bus();

    h264_bitstream_packer #(.BUF_W(192), .ACCEPT_TH(64), .CNT_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          q[$];
    bit          flushing;
    bit          pend_fd;
    bit          m_live;
    logic [23:0] m_cnt;
    int          wait_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_rdy();
        return m_live && !flushing && (q.size() <= 64);
    endfunction

    task automatic drive(input bit v, input bit [6:0] len, input logic [127:0] code,
                         input bit fl, input bit wr);
        bus.cavlc_enc_valid      = v;
        bus.cavlc_bitstream_bit  = len;
        bus.cavlc_bitstream_code = code;
        bus.flush_req            = fl;
        bus.word_ready           = wr;
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model past the edge.
    task automatic step(input bit v, input bit [6:0] len, input logic [127:0] code,
                        input bit fl, input bit wr);
        bit          exp_rdy;
        bit          is_last;
        bit          whs;
        bit          new_pend;
        logic [31:0] ew;
        int          n;
        exp_rdy = model_rdy();
        is_last = 1'b0;
        check_val("packer_ready", bus.packer_ready, exp_rdy);
        check_val("flush_done", bus.flush_done, pend_fd);
        check_val("word_cnt", bus.word_cnt, m_cnt);
        if (pend_fd) begin
            check_val("word_valid_done", bus.word_valid, 0);
        end else if (!flushing || q.size() >= 32) begin
            check_val("word_valid", bus.word_valid, q.size() >= 32);
            if (q.size() >= 32) begin
                for (int i = 0; i < 32; i++) ew[31-i] = q[i];
                check_val("word_data", bus.word_data, ew);
                check_val("word_last", bus.word_last, 0);
                check_val("word_bytes", bus.word_bytes, 4);
            end
            wait_cnt = 0;
        end else if (bus.word_valid) begin
            is_last = 1'b1;
            n  = q.size();
            ew = '0;
            for (int i = 0; i < n; i++) ew[31-i] = q[i];
            ew[31-n] = 1'b1;
            check_val("last_data", bus.word_data, ew);
            check_val("last_flag", bus.word_last, 1);
            check_val("last_bytes", bus.word_bytes, (n + 8) / 8);
        end else begin
            wait_cnt++;
            if (wait_cnt == 9) check_val("flush_timeout", wait_cnt, 0);
        end

        drive(v, len, code, fl, wr);
        whs      = bus.word_valid && wr;
        new_pend = 1'b0;
        if (pend_fd) flushing = 1'b0;
        if (whs) begin
            m_cnt++;
            if (is_last) begin
                q.delete();
                new_pend = 1'b1;
                wait_cnt = 0;
            end else if (q.size() >= 32) begin
                repeat (32) void'(q.pop_front());
            end
        end
        if (v && exp_rdy)
            for (int i = int'(len) - 1; i >= 0; i--) q.push_back(code[i]);
        if (fl && exp_rdy) flushing = 1'b1;
        pend_fd = new_pend;
        m_live  = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit wr);
        repeat (n) step(0, 7'd0, '0, 0, wr);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 7'd0, '0, 0, 0);
        #1;
        check_val("rst_word_valid", bus.word_valid, 0);
        check_val("rst_word_last", bus.word_last, 0);
        check_val("rst_word_bytes", bus.word_bytes, 4);
        check_val("rst_word_data", bus.word_data, 0);
        check_val("rst_flush_done", bus.flush_done, 0);
        check_val("rst_packer_ready", bus.packer_ready, 0);
        check_val("rst_word_cnt", bus.word_cnt, 0);
        q.delete();
        flushing = 0;
        pend_fd  = 0;
        m_live   = 0;
        m_cnt    = '0;
        wait_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [127:0] ones;
        logic [127:0] rc;
        bit           sent;
        int           guard;
        ones = '1;
        rst  = 1'b1;
        drive(0, 7'd0, '0, 0, 0);
        @(negedge clk);
        do_reset();

        // Single short codeword then flush: 10110 + stop bit -> 0xB4000000
        step(1, 7'd5, 128'h16, 0, 1);
        step(0, 7'd0, '0, 1, 1);
        idle(8, 1);

        // Four bytes make one full word
        step(1, 7'd8, 128'h12, 0, 1);
        step(1, 7'd8, 128'h34, 0, 1);
        step(1, 7'd8, 128'h56, 0, 1);
        step(1, 7'd8, 128'h78, 0, 1);
        idle(3, 1);
        step(0, 7'd0, '0, 1, 1);
        idle(8, 1);

        // Long all-ones codewords under back-pressure
        step(1, 7'd127, ones, 0, 0);
        idle(3, 0);
        sent  = 0;
        guard = 0;
        while (!sent && guard < 20) begin
            sent = model_rdy();
            step(1, 7'd127, ones, 0, 1);
            guard++;
        end
        check_val("second_accept", sent, 1);
        idle(12, 1);
        step(0, 7'd0, '0, 1, 1);
        idle(8, 1);

        // Zero-length codewords interleaved with real ones
        step(1, 7'd0, ones, 0, 1);
        step(1, 7'd3, 128'h5, 0, 1);
        step(1, 7'd0, ones, 0, 1);
        step(1, 7'd29, 128'h0, 0, 1);
        step(1, 7'd0, ones, 0, 1);
        idle(3, 1);
        step(0, 7'd0, '0, 1, 1);
        idle(8, 1);

        // Accept and emit in the same cycle across the word boundary
        rc = {$urandom, $urandom, $urandom, $urandom};
        step(1, 7'd40, rc, 0, 0);
        rc = {$urandom, $urandom, $urandom, $urandom};
        step(1, 7'd20, rc, 0, 1);
        idle(3, 1);
        step(0, 7'd0, '0, 1, 1);
        idle(8, 1);

        // Reset while draining with 70 bits buffered
        rc = {$urandom, $urandom, $urandom, $urandom};
        step(1, 7'd40, rc, 0, 0);
        rc = {$urandom, $urandom, $urandom, $urandom};
        step(1, 7'd30, rc, 1, 0);
        idle(2, 0);
        do_reset();
        step(0, 7'd0, '0, 0, 1);
        step(0, 7'd0, '0, 1, 1);
        idle(8, 1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rc = {$urandom, $urandom, $urandom, $urandom};
            step($urandom_range(0, 1), 7'($urandom_range(0, 127)), rc,
                 $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
        end
        idle(12, 1);
        step(0, 7'd0, '0, 1, 1);
        idle(10, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
